// File: rtl/param_stack_if.sv
// ---------------------------------------------------------------------------
// param_stack_if
// Handshake/status bundle between a producer/consumer and the param_stack
// LIFO core.
//   Push, Pop : push/pop requests, sampled on the rising clock edge
//   D         : data to push (WIDTH bits)
//   Q         : registered top-of-stack value, 0 when empty
//   Count     : number of valid entries, 0..DEPTH (CW bits)
//   Empty/Full: decoded from the registered Count
//   Ovf/Udf   : overflow / underflow error flags
// Modports: master = requester side, slave = stack side.
// ---------------------------------------------------------------------------
interface param_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             Push;
  logic             Pop;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [CW-1:0]    Count;
  logic             Empty;
  logic             Full;
  logic             Ovf;
  logic             Udf;

  modport master (
    output Push, Pop, D,
    input  Q, Count, Empty, Full, Ovf, Udf
  );

  modport slave (
    input  Push, Pop, D,
    output Q, Count, Empty, Full, Ovf, Udf
  );
endinterface

// File: rtl/param_stack.sv
// ---------------------------------------------------------------------------
// param_stack
// Parametrised synchronous LIFO stack with push/pop handshaking, occupancy
// count, full/empty status and overflow/underflow flags.
// Ports:
//   Clk : rising-edge clock
//   Clr : asynchronous, active-high reset (clears Q/Count/flags, not storage)
//   bus : param_stack_if.slave (Push, Pop, D in; Q, Count, Empty, Full,
//         Ovf, Udf out)
// Optional build macro STACK_ERR_STICKY_EN: when defined, Ovf and Udf stay
// set until Clr; when undefined they are single-cycle pulses.
// ---------------------------------------------------------------------------
module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic          Clk,
  input  logic          Clr,
  param_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  // Storage is never reset; only the pointer/count defines validity.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] top_q,   top_d;
  logic             ovf_q,   ovf_d;
  logic             udf_q,   udf_d;

  logic             mem_we_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;
  logic             is_empty_s;
  logic             is_full_s;

  assign is_empty_s = (count_q == CNT_ZERO);
  assign is_full_s  = (count_q == CNT_DEPTH);

  // Entry just below the top (mem[sp-2]) becomes the new top after a pop.
  assign rd_idx_s = AW'(count_q - CNT_TWO);

  // Next-state logic for count, top-of-stack, error flags and storage write.
  always_comb begin
    count_d  = count_q;
    top_d    = top_q;
`ifdef STACK_ERR_STICKY_EN
    ovf_d    = ovf_q;
    udf_d    = udf_q;
`else
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
`endif
    mem_we_s = 1'b0;
    wr_idx_s = AW'(count_q);

    case ({bus.Push, bus.Pop})
      2'b10: begin
        if (is_full_s) begin
          ovf_d = 1'b1;
        end else begin
          mem_we_s = 1'b1;
          wr_idx_s = AW'(count_q);
          count_d  = count_q + CNT_ONE;
          top_d    = bus.D;
        end
      end
      2'b01: begin
        if (is_empty_s) begin
          udf_d = 1'b1;
        end else if (count_q == CNT_ONE) begin
          count_d = CNT_ZERO;
          top_d   = {WIDTH{1'b0}};
        end else begin
          count_d = count_q - CNT_ONE;
          top_d   = mem[rd_idx_s];
        end
      end
      2'b11: begin
        mem_we_s = 1'b1;
        top_d    = bus.D;
        if (is_empty_s) begin
          // Nothing to pop: behaves as a plain push.
          wr_idx_s = AW'(count_q);
          count_d  = CNT_ONE;
        end else begin
          // Replace the top entry in place; count is unchanged.
          wr_idx_s = AW'(count_q - CNT_ONE);
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Control/status registers with asynchronous clear.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      count_q <= CNT_ZERO;
      top_q   <= {WIDTH{1'b0}};
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage write port; requests are ignored while Clr is held.
  always_ff @(posedge Clk) begin
    if (mem_we_s && !Clr) begin
      mem[wr_idx_s] <= bus.D;
    end
  end

  assign bus.Q     = top_q;
  assign bus.Count = count_q;
  assign bus.Empty = is_empty_s;
  assign bus.Full  = is_full_s;
  assign bus.Ovf   = ovf_q;
  assign bus.Udf   = udf_q;
endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;
`ifdef STACK_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk;
  logic clr;
  int   pass_cnt;
  int   chk_cnt;

  param_stack_if #(.WIDTH(8), .DEPTH(8)) bus ();

  param_stack #(.WIDTH(8), .DEPTH(8)) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed status vector: {Q, Count, Empty, Full, Ovf, Udf}
  function automatic logic [15:0] obs();
    return {bus.Q, bus.Count, bus.Empty, bus.Full, bus.Ovf, bus.Udf};
  endfunction

  function automatic logic [15:0] st(input logic [7:0] q, input logic [3:0] c,
                                     input logic e, input logic f,
                                     input logic o, input logic u);
    return {q, c, e, f, o, u};
  endfunction

  // One clock with the given requests, then back to idle; sample 1 time unit after the edge.
  task automatic drive(input logic push, input logic pop, input logic [7:0] d);
    bus.Push = push;
    bus.Pop  = pop;
    bus.D    = d;
    @(posedge clk);
    #1;
    bus.Push = 1'b0;
    bus.Pop  = 1'b0;
  endtask

  task automatic reset_dut();
    clr = 1'b1;
    #2;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    clr = 1'b1;
    #1;
    e = st(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL reset_init got %h exp %h", obs(), e); else pass_cnt++;
    @(posedge clk); #1;
    clr = 1'b0;
    drive(1'b1, 1'b0, 8'hA1);
    drive(1'b1, 1'b0, 8'hA2);
    drive(1'b1, 1'b0, 8'hA3);
    e = st(8'hA3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL reset_pre got %h exp %h", obs(), e); else pass_cnt++;
    #2;
    clr = 1'b1;
    #1;
    e = st(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL reset_async got %h exp %h", obs(), e); else pass_cnt++;
    // Requests while Clr is high are ignored.
    drive(1'b1, 1'b0, 8'h55);
    chk_cnt++;
    if (obs() !== e) $display("FAIL reset_ignore got %h exp %h", obs(), e); else pass_cnt++;
    clr = 1'b0;
  endtask

  task automatic test_lifo();
    logic [7:0]  q_exp [6];
    logic [3:0]  c_exp [6];
    logic [15:0] e;
    q_exp = '{8'h11, 8'h22, 8'h33, 8'h22, 8'h11, 8'h00};
    c_exp = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b1, 1'b0, q_exp[i]);
      else       drive(1'b0, 1'b1, 8'hFF);
      e = st(q_exp[i], c_exp[i], (c_exp[i] == 4'd0), 1'b0, 1'b0, 1'b0);
      chk_cnt++;
      if (obs() !== e) $display("FAIL lifo_step%0d got %h exp %h", i, obs(), e); else pass_cnt++;
    end
  endtask

  task automatic test_fill_overflow();
    logic [15:0] e;
    reset_dut();
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, 8'(i));
    e = st(8'h08, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL fill_full got %h exp %h", obs(), e); else pass_cnt++;
    drive(1'b1, 1'b0, 8'hAA);
    e = st(8'h08, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL ovf_set got %h exp %h", obs(), e); else pass_cnt++;
    drive(1'b0, 1'b0, 8'h00);
    e = st(8'h08, 4'd8, 1'b0, 1'b1, STICKY, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL ovf_idle got %h exp %h", obs(), e); else pass_cnt++;
    drive(1'b0, 1'b1, 8'h00);
    e = st(8'h07, 4'd7, 1'b0, 1'b0, STICKY, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL ovf_pop got %h exp %h", obs(), e); else pass_cnt++;
  endtask

  task automatic test_underflow();
    logic [15:0] e;
    reset_dut();
    drive(1'b0, 1'b1, 8'h00);
    e = st(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_cnt++;
    if (obs() !== e) $display("FAIL udf_set got %h exp %h", obs(), e); else pass_cnt++;
    drive(1'b0, 1'b0, 8'h00);
    e = st(8'h00, 4'd0, 1'b1, 1'b0, 1'b0, STICKY);
    chk_cnt++;
    if (obs() !== e) $display("FAIL udf_idle got %h exp %h", obs(), e); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [15:0] e;
    reset_dut();
    drive(1'b1, 1'b0, 8'h10);
    drive(1'b1, 1'b0, 8'h20);
    drive(1'b1, 1'b1, 8'h99);
    e = st(8'h99, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL sim_replace got %h exp %h", obs(), e); else pass_cnt++;
    drive(1'b0, 1'b1, 8'h00);
    e = st(8'h10, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL sim_pop got %h exp %h", obs(), e); else pass_cnt++;
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 8'h5A);
    e = st(8'h5A, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL sim_empty got %h exp %h", obs(), e); else pass_cnt++;
  endtask

  task automatic test_full_replace();
    logic [15:0] e;
    reset_dut();
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, 8'(i));
    drive(1'b1, 1'b1, 8'hEE);
    e = st(8'hEE, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL full_replace got %h exp %h", obs(), e); else pass_cnt++;
    drive(1'b0, 1'b1, 8'h00);
    e = st(8'h07, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (obs() !== e) $display("FAIL full_replace_pop got %h exp %h", obs(), e); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    bus.Push = 1'b0;
    bus.Pop  = 1'b0;
    bus.D    = 8'h00;
    clr      = 1'b0;
    test_reset();
    test_lifo();
    test_fill_overflow();
    test_underflow();
    test_simultaneous();
    test_full_replace();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
